// File: rtl/cpu_controller_fsm.sv
// ----------------------------------------------------------------------------
// cpu_controller_fsm : Moore control sequencer for the simple RISC CPU
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_controller_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       shift_zero,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Operand/compute/address states are split per instruction class so that the
  // class decided in DEC is carried in the state itself, not in extra flops.
  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM,
    S_GETA_ALU, S_GETA_CMP, S_GETA_LDR, S_GETA_STR,
    S_GETB_MOV, S_GETB_ALU, S_GETB_CMP,
    S_COMP_MOV, S_COMP_ALU, S_COMP_CMP, S_WREG,
    S_ADDR_LDR, S_ADDR_STR, S_LADDR_LDR, S_LADDR_STR,
    S_MRD1, S_MRD2, S_SGETD, S_SPASS, S_SWR, S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       shift_zero;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctrl_t;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST:       begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:       begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
      S_IF2:       begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
      S_UPC:       c.load_pc = 1'b1;
      S_WIMM:      begin c.nsel = 3'b001; c.vsel = 2'b10; c.write = 1'b1; end
      S_GETA_ALU, S_GETA_CMP, S_GETA_LDR, S_GETA_STR:
                   begin c.nsel = 3'b001; c.loada = 1'b1; end
      S_GETB_MOV, S_GETB_ALU, S_GETB_CMP:
                   begin c.nsel = 3'b100; c.loadb = 1'b1; end
      S_COMP_MOV:  begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_COMP_ALU:  c.loadc = 1'b1;
      S_COMP_CMP:  c.loads = 1'b1;
      S_WREG:      begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
      S_ADDR_LDR, S_ADDR_STR:
                   begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LADDR_LDR, S_LADDR_STR:
                   c.load_addr = 1'b1;
      S_MRD1:      begin c.addr_sel = 1'b0; c.mem_cmd = MEM_READ; end
      S_MRD2:      begin
                     c.addr_sel = 1'b0; c.mem_cmd = MEM_READ;
                     c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1;
                   end
      S_SGETD:     begin c.nsel = 3'b010; c.loadb = 1'b1; end
      S_SPASS:     begin c.asel = 1'b1; c.shift_zero = 1'b1; c.loadc = 1'b1; end
      S_SWR:       begin c.addr_sel = 1'b0; c.mem_cmd = MEM_WRITE; end
      S_HALT:      c.halted = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:       state_nxt = S_IF1;
      S_IF1:       state_nxt = S_IF2;
      S_IF2:       state_nxt = S_UPC;
      S_UPC:       state_nxt = S_DEC;
      S_DEC: begin
        case (opcode)
          3'b110: begin
            if (op == 2'b10)      state_nxt = S_WIMM;
            else if (op == 2'b00) state_nxt = S_GETB_MOV;
            else                  state_nxt = S_IF1;
          end
          3'b101: begin
            case (op)
              2'b01:   state_nxt = S_GETA_CMP;
              2'b11:   state_nxt = S_GETB_ALU;
              default: state_nxt = S_GETA_ALU;
            endcase
          end
          3'b011:  state_nxt = S_GETA_LDR;
          3'b100:  state_nxt = S_GETA_STR;
          3'b111:  state_nxt = S_HALT;
          default: state_nxt = S_IF1;
        endcase
      end
      S_WIMM:      state_nxt = S_IF1;
      S_GETA_ALU:  state_nxt = S_GETB_ALU;
      S_GETA_CMP:  state_nxt = S_GETB_CMP;
      S_GETA_LDR:  state_nxt = S_ADDR_LDR;
      S_GETA_STR:  state_nxt = S_ADDR_STR;
      S_GETB_MOV:  state_nxt = S_COMP_MOV;
      S_GETB_ALU:  state_nxt = S_COMP_ALU;
      S_GETB_CMP:  state_nxt = S_COMP_CMP;
      S_COMP_MOV:  state_nxt = S_WREG;
      S_COMP_ALU:  state_nxt = S_WREG;
      S_COMP_CMP:  state_nxt = S_IF1;
      S_WREG:      state_nxt = S_IF1;
      S_ADDR_LDR:  state_nxt = S_LADDR_LDR;
      S_ADDR_STR:  state_nxt = S_LADDR_STR;
      S_LADDR_LDR: state_nxt = S_MRD1;
      S_LADDR_STR: state_nxt = S_SGETD;
      S_MRD1:      state_nxt = S_MRD2;
      S_MRD2:      state_nxt = S_IF1;
      S_SGETD:     state_nxt = S_SPASS;
      S_SPASS:     state_nxt = S_SWR;
      S_SWR:       state_nxt = S_IF1;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_RST;
    endcase
  end

  // Outputs are registered from the next state, so they always equal decode(state).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RST;
      ctrl  <= decode(S_RST);
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
    end
  end

  assign nsel       = ctrl.nsel;
  assign vsel       = ctrl.vsel;
  assign loada      = ctrl.loada;
  assign loadb      = ctrl.loadb;
  assign loadc      = ctrl.loadc;
  assign loads      = ctrl.loads;
  assign asel       = ctrl.asel;
  assign bsel       = ctrl.bsel;
  assign shift_zero = ctrl.shift_zero;
  assign write      = ctrl.write;
  assign load_ir    = ctrl.load_ir;
  assign load_pc    = ctrl.load_pc;
  assign reset_pc   = ctrl.reset_pc;
  assign addr_sel   = ctrl.addr_sel;
  assign load_addr  = ctrl.load_addr;
  assign mem_cmd    = ctrl.mem_cmd;
  assign halted     = ctrl.halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller_fsm.sv
// ----------------------------------------------------------------------------
// tb_cpu_controller_fsm : directed bench with an instruction-level control model
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cpu_controller_fsm;

  logic       clk;
  logic       reset_n;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, shift_zero, write;
  logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;
  logic [1:0] mem_cmd;

  cpu_controller_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .shift_zero(shift_zero),
    .write(write), .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit masks, packed as {nsel,vsel,loada..load_addr,mem_cmd,halted}
  localparam logic [20:0] M_HALTED = 21'd1;
  localparam logic [20:0] M_RD     = 21'd1 << 1;
  localparam logic [20:0] M_WR     = 21'd2 << 1;
  localparam logic [20:0] M_LADDR  = 21'd1 << 3;
  localparam logic [20:0] M_APC    = 21'd1 << 4;
  localparam logic [20:0] M_RPC    = 21'd1 << 5;
  localparam logic [20:0] M_LPC    = 21'd1 << 6;
  localparam logic [20:0] M_LIR    = 21'd1 << 7;
  localparam logic [20:0] M_WRITE  = 21'd1 << 8;
  localparam logic [20:0] M_SZ     = 21'd1 << 9;
  localparam logic [20:0] M_BSEL   = 21'd1 << 10;
  localparam logic [20:0] M_ASEL   = 21'd1 << 11;
  localparam logic [20:0] M_LOADS  = 21'd1 << 12;
  localparam logic [20:0] M_LOADC  = 21'd1 << 13;
  localparam logic [20:0] M_LOADB  = 21'd1 << 14;
  localparam logic [20:0] M_LOADA  = 21'd1 << 15;
  localparam logic [20:0] V_IMM    = 21'd2 << 16;
  localparam logic [20:0] V_MDATA  = 21'd3 << 16;
  localparam logic [20:0] N_RN     = 21'd1 << 18;
  localparam logic [20:0] N_RD     = 21'd2 << 18;
  localparam logic [20:0] N_RM     = 21'd4 << 18;
  localparam logic [20:0] W_RESET  = M_RPC | M_LPC;

  logic [20:0] dut_word;
  assign dut_word = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, shift_zero,
                     write, load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [20:0] exp_q[$];
  logic [20:0] mdl_q[$];

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level model: the per-cycle control words one instruction produces,
  // starting at IF1, composed from fetch, operand reads, compute and memory phases.
  task automatic model_build(input logic [2:0] opc, input logic [1:0] o, input int hold);
    bit mov_imm, mov_reg, mvn, alu, cmp, ldr, str, hlt;
    mdl_q.delete();
    mov_imm = (opc == 3'b110) && (o == 2'b10);
    mov_reg = (opc == 3'b110) && (o == 2'b00);
    mvn     = (opc == 3'b101) && (o == 2'b11);
    cmp     = (opc == 3'b101) && (o == 2'b01);
    alu     = (opc == 3'b101) && (o == 2'b00 || o == 2'b10);
    ldr     = (opc == 3'b011);
    str     = (opc == 3'b100);
    hlt     = (opc == 3'b111);
    mdl_q.push_back(M_APC | M_RD);
    mdl_q.push_back(M_APC | M_RD | M_LIR);
    mdl_q.push_back(M_LPC);
    mdl_q.push_back(21'd0);
    if (mov_imm) mdl_q.push_back(N_RN | V_IMM | M_WRITE);
    if (alu || cmp || ldr || str) mdl_q.push_back(N_RN | M_LOADA);
    if (mov_reg || mvn || alu || cmp) begin
      mdl_q.push_back(N_RM | M_LOADB);
      if (cmp) mdl_q.push_back(M_LOADS);
      else begin
        mdl_q.push_back(M_LOADC | (mov_reg ? M_ASEL : 21'd0));
        mdl_q.push_back(N_RD | M_WRITE);
      end
    end
    if (ldr || str) begin
      mdl_q.push_back(M_BSEL | M_LOADC);
      mdl_q.push_back(M_LADDR);
    end
    if (ldr) begin
      mdl_q.push_back(M_RD);
      mdl_q.push_back(M_RD | N_RD | V_MDATA | M_WRITE);
    end
    if (str) begin
      mdl_q.push_back(N_RD | M_LOADB);
      mdl_q.push_back(M_ASEL | M_SZ | M_LOADC);
      mdl_q.push_back(M_WR);
    end
    if (hlt) for (int i = 0; i < hold; i++) mdl_q.push_back(M_HALTED);
  endtask

  // Compare process: one expected word per cycle while a sequence is queued
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() != 0) check($sformatf("ctrl_cyc%0d", cyc), dut_word, exp_q.pop_front());
  end

  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input bit scramble,
                           input int hold);
    int len;
    @(posedge clk); #2;
    opcode = opc;
    op     = o;
    model_build(opc, o, hold);
    len = mdl_q.size();
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (scramble && k == 5) begin
        #1;
        opcode = ~opc;
        op     = ~o;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    opcode  = 3'b000;
    op      = 2'b00;

    // Hand-computed expectations pinning the model
    model_build(3'b110, 2'b10, 0);
    check_int("len_mov_imm", mdl_q.size(), 5);
    check("mdl_if1", mdl_q[0], 21'h000012);
    check("mdl_wimm", mdl_q[4], 21'h060100);
    model_build(3'b101, 2'b00, 0);
    check_int("len_add", mdl_q.size(), 8);
    check("mdl_add_comp", mdl_q[6], 21'h002000);
    model_build(3'b101, 2'b01, 0);
    check_int("len_cmp", mdl_q.size(), 7);
    check("mdl_cmp_comp", mdl_q[6], 21'h001000);
    model_build(3'b110, 2'b00, 0);
    check_int("len_mov_reg", mdl_q.size(), 7);
    model_build(3'b011, 2'b00, 0);
    check_int("len_ldr", mdl_q.size(), 9);
    check("mdl_mrd2", mdl_q[8], 21'h0B0102);
    model_build(3'b100, 2'b00, 0);
    check_int("len_str", mdl_q.size(), 10);
    check("mdl_swr", mdl_q[9], 21'h000004);
    model_build(3'b000, 2'b00, 0);
    check_int("len_nop", mdl_q.size(), 4);

    // Asynchronous reset asserted between clock edges
    #2 reset_n = 1'b0;
    #1 check("reset_async", dut_word, W_RESET);
    repeat (2) @(posedge clk);
    #2 check("reset_hold", dut_word, W_RESET);
    reset_n = 1'b1;

    run_instr(3'b110, 2'b10, 1'b0, 0);  // MOV R0,#-3
    run_instr(3'b101, 2'b00, 1'b1, 0);  // ADD
    run_instr(3'b101, 2'b01, 1'b1, 0);  // CMP
    run_instr(3'b110, 2'b00, 1'b1, 0);  // MOV Rd,Rm
    run_instr(3'b101, 2'b11, 1'b1, 0);  // MVN
    run_instr(3'b101, 2'b10, 1'b0, 0);  // AND
    run_instr(3'b011, 2'b00, 1'b1, 0);  // LDR
    run_instr(3'b100, 2'b00, 1'b1, 0);  // STR
    run_instr(3'b100, 2'b11, 1'b0, 0);  // STR, op ignored
    run_instr(3'b000, 2'b00, 1'b0, 0);  // NOP encodings
    run_instr(3'b001, 2'b11, 1'b0, 0);
    run_instr(3'b110, 2'b01, 1'b0, 0);
    run_instr(3'b110, 2'b11, 1'b0, 0);

    // Reset in the middle of an ADD
    @(posedge clk); #2;
    opcode = 3'b101;
    op     = 2'b00;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_mid_instr", dut_word, W_RESET);
    @(posedge clk);
    #2 check("reset_mid_hold", dut_word, W_RESET);
    reset_n = 1'b1;
    run_instr(3'b101, 2'b00, 1'b0, 0);

    // HALT holds for 20 cycles despite opcode changes; only reset exits
    run_instr(3'b111, 2'b00, 1'b1, 20);
    @(posedge clk); #3 reset_n = 1'b0;
    #1 check("reset_from_halt", dut_word, W_RESET);
    #3 reset_n = 1'b1;
    run_instr(3'b000, 2'b00, 1'b0, 0);
    run_instr(3'b011, 2'b00, 1'b0, 0);

    @(posedge clk); #2;
    check_int("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
